// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch/PC sequencer.
package mips_pkg;

  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_REG    = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_EXEC   = 2'b10,
    ST_HALTED = 2'b11
  } seq_state_e;

  localparam logic [1:0] TRAP_NONE     = 2'b00;
  localparam logic [1:0] TRAP_MISALIGN = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT  = 2'b10;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0180;

  // J-type target: upper nibble of PC+4 concatenated with the word index.
  function automatic logic [31:0] jump_target(input logic [31:0] plus4,
                                              input logic [25:0] index);
    return {plus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer and imem.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/next_pc_mux.sv
// Combinational next-PC candidate selection with word-alignment check.
module next_pc_mux
  import mips_pkg::*;
(
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] pc_plus4_in,
  input  logic [31:0] pc_target_in,
  input  logic [31:0] reg_target_in,
  input  logic [25:0] instr_index,
  output logic [31:0] candidate,
  output logic        misaligned
);

  always_comb begin
    candidate = pc_plus4_in;
    case (pc_src_e'(pc_src))
      PCSRC_PLUS4:  candidate = pc_plus4_in;
      PCSRC_BRANCH: candidate = branch_taken ? pc_target_in : pc_plus4_in;
      PCSRC_JUMP:   candidate = jump_target(pc_plus4_in, instr_index);
      PCSRC_REG:    candidate = reg_target_in;
      default:      candidate = pc_plus4_in;
    endcase
  end

  assign misaligned = (candidate[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/PC controller: owns the PC, fetches from variable-latency imem,
// presents one instruction per EXEC cycle and traps on faults.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
  parameter int          TIMEOUT      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pc_sequencer_if.master        imem,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [31:0]           pc,
  input  logic [31:0]           pc_plus4_in,
  input  logic [31:0]           pc_target_in,
  input  logic [31:0]           reg_target_in,
  input  logic [1:0]            pc_src,
  input  logic                  branch_taken,
  input  logic                  stall,
  input  logic                  halt,
  output logic                  halted,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [31:0]           retired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_e       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      retired_q, retired_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;

  logic [31:0]      candidate;
  logic             misaligned;

  next_pc_mux u_next_pc_mux (
    .pc_src        (pc_src),
    .branch_taken  (branch_taken),
    .pc_plus4_in   (pc_plus4_in),
    .pc_target_in  (pc_target_in),
    .reg_target_in (reg_target_in),
    .instr_index   (instr_q[25:0]),
    .candidate     (candidate),
    .misaligned    (misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_VECTOR;
      instr_q   <= '0;
      cnt_q     <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= TRAP_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    retired_d = retired_q;
    trap_d    = 1'b0;
    cause_d   = cause_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        // A response on the terminal-count cycle beats the timeout.
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          trap_d  = 1'b1;
          cause_d = TRAP_TIMEOUT;
          pc_d    = TRAP_VECTOR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          if (misaligned) begin
            pc_d    = TRAP_VECTOR;
            trap_d  = 1'b1;
            cause_d = TRAP_MISALIGN;
          end else begin
            pc_d = candidate;
          end
          retired_d = retired_q + 32'd1;
          state_d   = halt ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign imem.imem_req  = (state_q == ST_FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = (state_q == ST_EXEC);
  assign pc             = pc_q;
  assign halted         = (state_q == ST_HALTED);
  assign trap           = trap_q;
  assign trap_cause     = cause_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random
// fetch/exec traffic against a transaction-level reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_VEC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0180;
  localparam int          TMO      = 16;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4_in;
  logic [31:0] pc_target_in;
  logic [31:0] reg_target_in;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic        stall;
  logic        halt;
  logic        halted;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR (RST_VEC),
    .TRAP_VECTOR  (TRAP_VEC),
    .TIMEOUT      (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (bus),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4_in   (pc_plus4_in),
    .pc_target_in  (pc_target_in),
    .reg_target_in (reg_target_in),
    .pc_src        (pc_src),
    .branch_taken  (branch_taken),
    .stall         (stall),
    .halt          (halt),
    .halted        (halted),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .retired       (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_retired;
  logic [1:0]  m_cause;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reset, optionally asserted part-way through a cycle; returns in first FETCH cycle.
  task automatic do_reset(input bit mid);
    if (mid) #3;
    reset = 1'b1;
    bus.imem_ready = 1'b0;
    stall = 1'b0;
    halt  = 1'b0;
    #1;
    m_pc = RST_VEC; m_instr = '0; m_retired = '0; m_cause = 2'b00;
    check("rst_pc",      pc,                   m_pc);
    check("rst_instr",   instr,                32'h0);
    check("rst_valid",   32'(instr_valid),     32'h0);
    check("rst_req",     32'(bus.imem_req),    32'h0);
    check("rst_halted",  32'(halted),          32'h0);
    check("rst_trap",    32'(trap),            32'h0);
    check("rst_cause",   32'(trap_cause),      32'h0);
    check("rst_retired", retired,              32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("idle_req",   32'(bus.imem_req), 32'h0);
    check("idle_valid", 32'(instr_valid),  32'h0);
    @(posedge clk); #1;
  endtask

  // Serve one fetch: ready is raised on FETCH cycle index lat (0-based).
  task automatic fetch(input int lat, input logic [31:0] word);
    int waited;
    waited = 0;
    for (int k = 0; k <= lat; k++) begin
      check("fetch_req",  32'(bus.imem_req), 32'h1);
      check("fetch_addr", bus.imem_addr,     m_pc);
      check("fetch_valid", 32'(instr_valid), 32'h0);
      bus.imem_ready = (k == lat);
      bus.imem_rdata = (k == lat) ? word : $urandom;
      @(posedge clk); #1;
      if (k != lat) begin
        waited++;
        if (waited == TMO) begin
          waited  = 0;
          m_pc    = TRAP_VEC;
          m_cause = 2'b10;
          check("tmo_trap", 32'(trap), 32'h1);
        end else begin
          check("fetch_trap", 32'(trap), 32'h0);
        end
        check("fetch_cause", 32'(trap_cause), 32'(m_cause));
      end
    end
    bus.imem_ready = 1'b0;
    m_instr = word;
    check("exec_valid", 32'(instr_valid),  32'h1);
    check("exec_instr", instr,             m_instr);
    check("exec_req",   32'(bus.imem_req), 32'h0);
  endtask

  // Execute the current instruction with the given datapath inputs.
  task automatic exec(input logic [1:0] src, input logic taken, input logic [31:0] p4,
                      input logic [31:0] tgt, input logic [31:0] rg,
                      input int stall_cycles, input logic hl);
    logic [31:0] cand;
    logic        bad;
    pc_src = src; branch_taken = taken;
    pc_plus4_in = p4; pc_target_in = tgt; reg_target_in = rg;
    halt = hl;
    for (int i = 0; i < stall_cycles; i++) begin
      stall = 1'b1;
      @(posedge clk); #1;
      check("stall_pc",     pc,                  m_pc);
      check("stall_valid",  32'(instr_valid),    32'h1);
      check("stall_instr",  instr,               m_instr);
      check("stall_ret",    retired,             m_retired);
      check("stall_halted", 32'(halted),         32'h0);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    case (src)
      2'd0:    cand = p4;
      2'd1:    cand = taken ? tgt : p4;
      2'd2:    cand = (p4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
      default: cand = rg;
    endcase
    bad = (cand % 4) != 0;
    m_retired = m_retired + 1;
    if (bad) begin
      m_pc = TRAP_VEC;
      m_cause = 2'b01;
    end else begin
      m_pc = cand;
    end
    check("next_pc",      pc,                 m_pc);
    check("next_trap",    32'(trap),          32'(bad));
    check("next_cause",   32'(trap_cause),    32'(m_cause));
    check("next_retired", retired,            m_retired);
    check("next_halted",  32'(halted),        32'(hl));
    check("next_valid",   32'(instr_valid),   32'h0);
    check("next_req",     32'(bus.imem_req),  32'(!hl));
    halt = 1'b0;
    if (hl) begin
      @(posedge clk); #1;
      check("halt_hold",  32'(halted),       32'h1);
      check("halt_req",   32'(bus.imem_req), 32'h0);
      check("halt_trap",  32'(trap),         32'h0);
      check("halt_pc",    pc,                m_pc);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  initial begin
    int          lat;
    int          st;
    logic        hl;
    logic [1:0]  src;
    logic        tk;
    logic [31:0] p4;
    logic [31:0] tg;
    logic [31:0] rg;

    reset = 1'b1; stall = 1'b0; halt = 1'b0;
    pc_src = 2'b00; branch_taken = 1'b0;
    pc_plus4_in = '0; pc_target_in = '0; reg_target_in = '0;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0;
    do_reset(1'b0);

    // Two-cycle memory latency, sequential step
    fetch(1, 32'h2008_0005);
    exec(2'b00, 1'b0, m_pc + 4, 32'h0, 32'h0, 0, 1'b0);
    // Branch taken, then not taken
    fetch(0, 32'h1000_0003);
    exec(2'b01, 1'b1, m_pc + 4, 32'h40, 32'h0, 0, 1'b0);
    fetch(2, 32'h1000_0004);
    exec(2'b01, 1'b0, m_pc + 4, 32'h80, 32'h0, 0, 1'b0);
    // Jump, then misaligned JR
    fetch(0, 32'h0800_0010);
    exec(2'b10, 1'b0, 32'h1000_0004, 32'h0, 32'h0, 0, 1'b0);
    fetch(3, 32'h03E0_0008);
    exec(2'b11, 1'b0, m_pc + 4, 32'h0, 32'h22, 0, 1'b0);
    // Fetch timeout at 16 cycles, then refetch from the trap vector
    fetch(TMO, 32'h2108_0001);
    // Ready exactly on the terminal-count cycle: no trap
    exec(2'b00, 1'b0, m_pc + 4, 32'h0, 32'h0, 0, 1'b0);
    fetch(TMO - 1, 32'h2108_0002);
    // Stall with halt held, then halt
    exec(2'b00, 1'b0, m_pc + 4, 32'h0, 32'h0, 3, 1'b1);
    do_reset(1'b1);

    // Reset mid-FETCH
    bus.imem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset(1'b1);
    // Reset mid-EXEC
    fetch(0, 32'h2008_0007);
    do_reset(1'b1);
    // Misaligned target together with halt
    fetch(1, 32'h2008_0009);
    exec(2'b01, 1'b1, 32'h4, 32'h42, 32'h0, 1, 1'b1);
    do_reset(1'b1);

    for (int t = 0; t < 60; t++) begin
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 1, TMO + 4) : $urandom_range(0, 4);
      fetch(lat, $urandom);
      src = 2'($urandom_range(0, 3));
      tk  = 1'($urandom_range(0, 1));
      p4  = rand_addr();
      tg  = rand_addr();
      rg  = rand_addr();
      st  = $urandom_range(0, 2);
      hl  = ($urandom_range(0, 9) == 0);
      exec(src, tk, p4, tg, rg, st, hl);
      if (hl) do_reset($urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
